vedic_seq_mult: RTL and testbench
=================================

Name: vedic_seq_mult

Overview:
- Parametrised, column-serial Urdhva-Tiryagbhyam (vertical-and-crosswise) multiplier.
- Generalises the half-adder building block into a WIDTH x WIDTH unsigned multiplier.
- Computes one crosswise column of partial products per clock cycle and accumulates the running carry.
- Uses a start/busy/done handshake and sits beside the combinational vedic multipliers as a low-area alternative.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16. Product width is 2*WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE.
- a, input, WIDTH, multiplicand; captured on the accepted start.
- b, input, WIDTH, multiplier; captured on the accepted start.
- product, output, 2*WIDTH, result register; valid while done=1 and held until the next accepted start.
- busy, output, 1, high while a multiplication is in progress.
- done, output, 1, single-cycle pulse marking product valid.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, product=0, busy=0, done=0, internal column counter and carry cleared.
- Reset wins over every other event, including mid-computation and during DONE. Any in-flight operation is discarded and no done is produced.
- States:
  - IDLE: start=1 latches a and b into internal registers, clears col and carry, clears product, sets busy=1, goes to COMPUTE. start=0 stays in IDLE.
  - COMPUTE: one column per cycle for col = 0 .. 2*WIDTH-2.
    - Column sum S = carry + sum over i of (a[i] & b[col-i]), where i ranges over 0 <= i < WIDTH and 0 <= col-i < WIDTH.
    - product[col] <= S[0]; carry <= S >> 1; col <= col+1.
  - Last column (col = 2*WIDTH-2): additionally product[2*WIDTH-1] <= S >> 1, which is guaranteed 0 or 1. Then busy<=0, done<=1, go to DONE.
  - DONE: one cycle with done=1, then done<=0 and go to IDLE unconditionally.
- Latency: start accepted at edge T0 -> done high for exactly one cycle after edge T0 + (2*WIDTH-1). For WIDTH=4 that is 7 cycles. Throughput is one result per 2*WIDTH+1 cycles.
- start while busy=1 or in DONE: ignored. It is not queued and a/b are not re-sampled.
- a and b may change freely after the accepted start; only the latched copies are used.
- Widths:
  - Column sum S is $clog2(WIDTH)+2 bits wide. The maximum is WIDTH plus a carry below WIDTH, so S never overflows.
  - carry is S width minus 1.
  - Full-range product: (2^WIDTH-1)^2 fits in 2*WIDTH bits with no truncation.
- Operands of 0 are processed normally, with no early termination; latency is constant.
- product is registered. Bits are filled LSB-first during COMPUTE and are valid as a whole only while done=1 and afterwards until the next accepted start.

Optional Feature:
- Macro: VEDIC_SEQ_MULT_SIGNED_EN.
- Defined: a, b and product are two's complement.
  - On the accepted start, latch |a| and |b| as WIDTH-bit unsigned values and latch sign = a[MSB] ^ b[MSB].
  - Column processing is unchanged.
  - On the transition into DONE, product is written as the negated magnitude when sign=1.
  - Latency is identical to the unsigned build.
  - -2^(WIDTH-1) is handled: its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits, and (-2^(WIDTH-1))^2 fits in a 2*WIDTH signed result.
- Undefined: purely unsigned operation as described above, with no sign logic synthesised.

Test Plan:
- WIDTH=4, after reset, a=13, b=11, start pulse -> busy=1 for 7 cycles; done pulses once at T0+7 with product=8'h8F (143); a subsequent idle cycle gives done=0 and product held at 143.
- WIDTH=4, a=15, b=15 -> product=8'hE1 (225); a=0, b=9 -> product=8'h00, still exactly 7 cycles.
- WIDTH=4, start a=6, b=7, then start again 3 cycles later with a=1, b=1 -> second start ignored; single done with product=42; a new start in IDLE is accepted.
- WIDTH=4, start a=9, b=9, assert rst at cycle 4 -> next cycle product=0, busy=0, done=0, state IDLE; no done pulse follows; a fresh a=2, b=3 afterwards gives 6.
- WIDTH=8, a=255, b=255 -> product=16'hFE01 with done at T0+15; WIDTH=8, a=1, b=200 -> 200.
- VEDIC_SEQ_MULT_SIGNED_EN, WIDTH=4: a=-3 (4'hD), b=5 -> product=8'hF1 (-15); a=-8, b=-8 -> 8'h40 (64); a=-8, b=7 -> 8'hC8 (-56); all 7-cycle latency.

Source files
------------

// File: rtl/vedic_seq_mult.sv
// Column-serial Urdhva-Tiryagbhyam multiplier, one crosswise column per clock.
// Optional VEDIC_SEQ_MULT_SIGNED_EN builds the two's complement variant.
module vedic_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int PW  = 2 * WIDTH;
  localparam int SW  = $clog2(WIDTH) + 2;
  localparam int CRW = SW - 1;
  localparam int CW  = $clog2(PW);

  localparam logic [CW-1:0] LAST = CW'(PW - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    col_q;
  logic [CRW-1:0]   carry_q;
  logic [SW-1:0]    col_sum;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    fin;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

`ifdef VEDIC_SEQ_MULT_SIGNED_EN
  logic sign_q;

  // Column logic works on magnitudes; the sign is reapplied at the end.
  always_comb begin
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;
    fin   = sign_q ? -mag : mag;
  end

  // Result sign is captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  // Unsigned build passes operands and result straight through.
  always_comb begin
    a_abs = a;
    b_abs = b;
    fin   = mag;
  end
`endif

  // Crosswise sum of every a[i]&b[j] with i+j on the current column.
  always_comb begin
    col_sum = SW'(carry_q);
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j == int'(col_q)) begin
          col_sum = col_sum + SW'(a_q[i] & b_q[j]);
        end
      end
    end
  end

  // Final column supplies the top two bits; the rest are already stored.
  always_comb begin
    mag = {col_sum[1:0], product[PW-3:0]};
  end

  // Control FSM plus column accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      col_q   <= '0;
      carry_q <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_abs;
            b_q     <= b_abs;
            col_q   <= '0;
            carry_q <= '0;
            product <= '0;
            busy    <= 1'b1;
            state_q <= S_COMP;
          end
        end
        S_COMP: begin
          carry_q <= col_sum[SW-1:1];
          col_q   <= col_q + CW'(1);
          if (col_q == LAST) begin
            product <= fin;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            product[col_q] <= col_sum[0];
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Bench for vedic_seq_mult: cycle model plus directed literal vectors.
// Expectations follow VEDIC_SEQ_MULT_SIGNED_EN when defined.
module tb_vedic_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [7:0]  product;
  logic        busy;
  logic        done;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] product8;
  logic        busy8;
  logic        done8;

  int total = 0;
  int bad   = 0;

  vedic_seq_mult #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .product(product), .busy(busy), .done(done)
  );

  vedic_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .done(done8)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] mul4(logic [3:0] x, logic [3:0] y);
`ifdef VEDIC_SEQ_MULT_SIGNED_EN
    logic signed [7:0] r;
    r = $signed(x) * $signed(y);
`else
    logic [7:0] r;
    r = x * y;
`endif
    return r;
  endfunction

  // Transaction-level model of the 4-bit unit.
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic [7:0] m_prod  = '0;
  logic [7:0] m_res   = '0;
  int         m_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_prod  <= '0;
      m_cnt   <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_res;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_cnt  <= 7;
      m_prod <= '0;
      m_res  <= mul4(a, b);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model busy", 32'(busy), 32'(m_busy));
      check("model done", 32'(done), 32'(m_done));
      if (!m_busy) check("model product", 32'(product), 32'(m_prod));
    end
  end

  task automatic run4(input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp, input string nm);
    int lat;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'd7);
    check({nm, " product"}, 32'(product), 32'(exp));
    @(negedge clk);
    check({nm, " done drop"}, 32'(done), 32'd0);
    check({nm, " hold"}, 32'(product), 32'(exp));
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp, input string nm);
    int lat;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = '0; b8 = '0;
    check({nm, " busy"}, 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'd15);
    check({nm, " product"}, 32'(product8), 32'(exp));
    @(negedge clk);
    check({nm, " done drop"}, 32'(done8), 32'd0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst product", 32'(product), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product8", 32'(product8), 32'd0);
    rst = 1'b0;

`ifdef VEDIC_SEQ_MULT_SIGNED_EN
    run4(4'd13, 4'd11, 8'h0F, "13x11");
    run4(4'd15, 4'd15, 8'h01, "15x15");
    run4(4'd0,  4'd9,  8'h00, "0x9");
    run4(4'hD,  4'd5,  8'hF1, "-3x5");
    run4(4'h8,  4'h8,  8'h40, "-8x-8");
    run4(4'h8,  4'd7,  8'hC8, "-8x7");
`else
    run4(4'd13, 4'd11, 8'h8F, "13x11");
    run4(4'd15, 4'd15, 8'hE1, "15x15");
    run4(4'd0,  4'd9,  8'h00, "0x9");
    run4(4'hD,  4'd5,  8'h41, "13x5");
    run4(4'h8,  4'h8,  8'h40, "8x8");
    run4(4'h8,  4'd7,  8'h38, "8x7");
`endif

    // Second start while busy must be ignored.
    @(negedge clk);
    a = 4'd6; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy-start latency", 32'(lat), 32'd7);
    check("busy-start product", 32'(product), 32'd42);
    count_done(12, nd);
    check("busy-start no 2nd done", 32'(nd), 32'd0);
    run4(4'd1, 4'd1, 8'd1, "1x1");

    // Reset mid-computation discards the operation.
    @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-rst product", 32'(product), 32'd0);
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst done", 32'(done), 32'd0);
    count_done(12, nd);
    check("mid-rst no done", 32'(nd), 32'd0);
    run4(4'd2, 4'd3, 8'd6, "2x3");

`ifdef VEDIC_SEQ_MULT_SIGNED_EN
    run8(8'd255, 8'd255, 16'h0001, "w8 255x255");
    run8(8'd1,   8'd200, 16'hFFC8, "w8 1x200");
`else
    run8(8'd255, 8'd255, 16'hFE01, "w8 255x255");
    run8(8'd1,   8'd200, 16'h00C8, "w8 1x200");
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
